// File: rtl/cdc_pulse_sender.sv
// Source side of a pulse crossing: queues local event strobes and launches each
// one as a 4-phase req/ack handshake towards an asynchronous far clock domain.
//
// state   | meaning
// IDLE    | no handshake in flight; launches when events are queued
// REQ     | req_out high, waiting for synchronized ack to rise
// RELEASE | req_out low, waiting for synchronized ack to fall
module cdc_pulse_sender #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             pulse_in,
  input  logic             ack_in,
  input  logic             err_clear,
  output logic             req_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             timeout_err
);

  // A zero TIMEOUT still needs a one-bit counter to keep the declarations legal.
  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_req;
  logic [TO_W-1:0]        r_to_cnt;
  logic                   r_timeout_err;
  logic                   r_overflow;
  logic [CNT_W-1:0]       r_pending;
  logic [SYNC_STAGES-1:0] r_ack_sync;

  logic w_ack_s;
  logic w_launch;
  logic w_to_hit;
  logic w_full;
  logic w_ovf_set;

  assign w_ack_s   = r_ack_sync[SYNC_STAGES-1];
  assign w_launch  = (r_state == S_IDLE) && (r_pending != '0);
  assign w_to_hit  = (TIMEOUT != 0) && (r_to_cnt == TO_LAST);
  assign w_full    = &r_pending;
  assign w_ovf_set = pulse_in && !w_launch && w_full;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_in};
    end
  end

  // A simultaneous event and launch leave the queue depth unchanged, even when full.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_pending <= '0;
    end else begin
      case ({pulse_in, w_launch})
        2'b10:   if (!w_full) r_pending <= r_pending + PEND_ONE;
        2'b01:   r_pending <= r_pending - PEND_ONE;
        default: r_pending <= r_pending;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (err_clear) begin
      r_overflow <= 1'b0;
    end
  end

  // Error clear is written first so a timeout in the same cycle overrides it.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state       <= S_IDLE;
      r_req         <= 1'b0;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (err_clear) r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req    <= 1'b0;
          r_to_cnt <= '0;
          if (w_launch) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
        end
        S_REQ: begin
          r_req <= 1'b1;
          if (w_ack_s) begin
            r_state  <= S_RELEASE;
            r_req    <= 1'b0;
            r_to_cnt <= '0;
          end else if (w_to_hit) begin
            r_state       <= S_RELEASE;
            r_req         <= 1'b0;
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_ONE;
          end
        end
        S_RELEASE: begin
          r_req <= 1'b0;
          if (!w_ack_s) begin
            r_state  <= S_IDLE;
            r_to_cnt <= '0;
          end else if (w_to_hit) begin
            r_state       <= S_IDLE;
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_ONE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_req    <= 1'b0;
          r_to_cnt <= '0;
        end
      endcase
    end
  end

  assign req_out     = r_req;
  assign busy        = (r_state != S_IDLE) || (r_pending != '0);
  assign pending     = r_pending;
  assign overflow    = r_overflow;
  assign timeout_err = r_timeout_err;

endmodule
